// File: rtl/imem_pkg.sv
// Shared types for the instruction memory: response record and parity helper.
// IMEM_PARITY_EN adds a perr field to the response record.
package imem_pkg;

  localparam int unsigned IMEM_ADDR_W = 16;
  localparam int unsigned IMEM_DATA_W = 32;

  typedef struct packed {
    logic [IMEM_DATA_W-1:0] data;
    logic [IMEM_ADDR_W-1:0] addr;
    logic                   fault;
`ifdef IMEM_PARITY_EN
    logic                   perr;
`endif
  } imem_rsp_t;

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic imem_parity(input logic [IMEM_DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/imem_rsp_buf.sv
// Two-entry response FIFO with occupancy count and synchronous clear.
module imem_rsp_buf
  import imem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  imem_rsp_t  i_push_data,
  input  logic       i_pop,
  input  logic       i_clear,
  output imem_rsp_t  o_head,
  output logic [1:0] o_count
);

  imem_rsp_t  r_entry [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       w_do_push;
  logic       w_do_pop;

  assign w_do_pop  = i_pop  && (r_count != 2'd0);
  assign w_do_push = i_push && (r_count != 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_clear) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset; consumers qualify it with the count.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_clear) r_entry[r_wr_ptr] <= i_push_data;
  end

  assign o_head  = r_entry[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/instr_mem_fetch.sv
// Instruction memory with valid/ready fetch port, 2-entry response buffer and load port.
// Optional IMEM_PARITY_EN: per-word even parity with injection and response error flag.
module instr_mem_fetch
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_fault,
  input  logic              flush,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
`ifdef IMEM_PARITY_EN
  ,
  input  logic              ld_perr_inj,
  output logic              rsp_perr
`endif
);

  localparam int unsigned      IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  LIMIT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
`ifdef IMEM_PARITY_EN
  logic              r_par [DEPTH];
`endif

  logic              w_req_in_range;
  logic              w_ld_ok;
  logic              w_accept;
  logic              w_valid;
  logic [1:0]        w_count;
  logic [IDX_W-1:0]  w_req_idx;
  logic [IDX_W-1:0]  w_ld_idx;
  imem_rsp_t         w_push;
  imem_rsp_t         w_head;

  assign w_req_in_range = {1'b0, req_addr} < LIMIT;
  assign w_ld_ok        = ld_en && ({1'b0, ld_addr} < LIMIT);
  assign w_req_idx      = req_addr[IDX_W-1:0];
  assign w_ld_idx       = ld_addr[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (w_ld_ok) begin
      r_mem[w_ld_idx] <= ld_data;
`ifdef IMEM_PARITY_EN
      r_par[w_ld_idx] <= imem_parity(IMEM_DATA_W'(ld_data)) ^ ld_perr_inj;
`endif
    end
  end

  // The buffer slot written at the accept edge doubles as the registered read,
  // so the credit check only needs the buffer occupancy.
  assign req_ready = rst_n && !flush && (w_count < 2'd2);
  assign w_accept  = req_valid && req_ready;

  always_comb begin
    w_push       = '0;
    w_push.addr  = IMEM_ADDR_W'(req_addr);
    w_push.fault = !w_req_in_range;
    if (w_req_in_range) begin
      w_push.data = IMEM_DATA_W'(r_mem[w_req_idx]);
`ifdef IMEM_PARITY_EN
      w_push.perr = imem_parity(IMEM_DATA_W'(r_mem[w_req_idx])) != r_par[w_req_idx];
`endif
    end
  end

  imem_rsp_buf u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_accept),
    .i_push_data (w_push),
    .i_pop       (rsp_ready),
    .i_clear     (flush),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  assign w_valid   = (w_count != 2'd0);
  assign rsp_valid = w_valid;
  assign rsp_data  = w_valid ? DATA_W'(w_head.data) : '0;
  assign rsp_addr  = w_valid ? ADDR_W'(w_head.addr) : '0;
  assign rsp_fault = w_valid && w_head.fault;
`ifdef IMEM_PARITY_EN
  assign rsp_perr  = w_valid && w_head.perr;
`endif

endmodule
